// File: rtl/fp_pkg.sv
// Shared definitions for the FP32 accumulator slice.
// Holds the format widths, derived datapath widths, canonical special
// encodings, the accumulator FSM state type, the special-result class and
// the unpacked-operand struct together with its unpack helper.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int WORD_W  = 1 + EXP_W + FRAC_W;
  localparam int MANT_W  = FRAC_W + 1;          // hidden bit + fraction
  localparam int EXT_W   = MANT_W + 3;          // + guard, round, sticky
  localparam int SUM_W   = FRAC_W + 5;          // + carry-out
  localparam int LZC_W   = $clog2(SUM_W + 1);
  localparam int EXPI_W  = EXP_W + 2;           // two's-complement working exponent
  localparam int BIAS    = 127;
  localparam int EXP_INF = 2 * BIAS + 1;        // all-ones biased exponent

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_OUT
  } state_e;

  // Result class decided in ALIGN; SP_NONE means "take the datapath result".
  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_INF,
    SP_ZERO
  } special_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

  // Subnormals are treated as signed zero: a zero exponent field always
  // yields is_zero with an all-zero mantissa.
  function automatic fp_unpacked_t fp_unpack(input logic [WORD_W-1:0] w);
    fp_unpacked_t      u;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e         = w[WORD_W-2 -: EXP_W];
    f         = w[FRAC_W-1:0];
    u.sign    = w[WORD_W-1];
    u.exp     = e;
    u.is_zero = (e == '0);
    u.is_inf  = (e == '1) && (f == '0);
    u.is_nan  = (e == '1) && (f != '0);
    u.mant    = u.is_zero ? '0 : {1'b1, f};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter used by the NORM stage.
// Ports:
//   vec   - input vector, MSB first
//   count - number of zeros above the most significant one (W when vec==0)
module fp_lzc
  import fp_pkg::*;
#(
  parameter int W     = SUM_W,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (vec[i]) count = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp32_acc.sv
// Sequential FP32 accumulator fed by the multiplier output stream.
// Each accepted element is added into a running sum through fixed
// ALIGN / ADD / NORM / ROUND stages (one cycle each); after an element
// flagged last the sum is offered on the output port and then cleared.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_data/valid/last   - element stream; in_ready high only in IDLE
//   out_data/valid       - final sum, held until out_ready
//   out_ready            - consumer accepts out_data
module fp32_acc
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] in_word_q, in_word_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  special_e          sp_q, sp_d;
  logic              sp_sign_q, sp_sign_d;
  logic              sign_q, sign_d;
  logic              sub_q, sub_d;
  logic [EXPI_W-1:0] exp_q, exp_d;
  logic [EXT_W-1:0]  a_ext_q, a_ext_d;
  logic [EXT_W-1:0]  b_ext_q, b_ext_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [EXT_W-1:0]  norm_q, norm_d;

  // ---------------------------------------------------------------- ALIGN
  fp_unpacked_t      op_acc, op_in;
  logic              swap;
  logic              big_sign;
  logic [EXP_W-1:0]  big_exp, small_exp, exp_diff;
  logic [MANT_W-1:0] big_mant, small_mant;
  logic [EXT_W-1:0]  small_ext, small_shr, small_al;
  special_e          al_sp;
  logic              al_sp_sign;

  always_comb begin : align_path
    op_acc     = fp_unpack(acc_q);
    op_in      = fp_unpack(in_word_q);
    swap       = {op_in.exp, op_in.mant} > {op_acc.exp, op_acc.mant};
    big_sign   = swap ? op_in.sign : op_acc.sign;
    big_exp    = swap ? op_in.exp  : op_acc.exp;
    big_mant   = swap ? op_in.mant : op_acc.mant;
    small_exp  = swap ? op_acc.exp  : op_in.exp;
    small_mant = swap ? op_acc.mant : op_in.mant;
    exp_diff   = big_exp - small_exp;
    small_ext  = {small_mant, 3'b000};
    small_shr  = small_ext >> exp_diff;
    // Bits pushed below the sticky position are OR-ed into it; a large
    // enough distance leaves nothing but the sticky bit.
    if (exp_diff >= EXP_W'(FRAC_W + 3)) begin
      small_al = {{(EXT_W-1){1'b0}}, |small_ext};
    end else begin
      small_al = small_shr | {{(EXT_W-1){1'b0}}, ((small_shr << exp_diff) != small_ext)};
    end

    al_sp      = SP_NONE;
    al_sp_sign = 1'b0;
    if (op_acc.is_nan || op_in.is_nan) begin
      al_sp = SP_NAN;
    end else if (op_acc.is_inf && op_in.is_inf) begin
      al_sp      = (op_acc.sign != op_in.sign) ? SP_NAN : SP_INF;
      al_sp_sign = op_acc.sign;
    end else if (op_acc.is_inf || op_in.is_inf) begin
      al_sp      = SP_INF;
      al_sp_sign = op_acc.is_inf ? op_acc.sign : op_in.sign;
    end else if (op_acc.is_zero && op_in.is_zero) begin
      // Only two negative zeros give a negative zero.
      al_sp      = SP_ZERO;
      al_sp_sign = op_acc.sign & op_in.sign;
    end
  end

  // ----------------------------------------------------------------- NORM
  logic [LZC_W-1:0] lzc;
  logic [LZC_W-1:0] lshift;
  logic [EXT_W-1:0] norm_shl;

  fp_lzc #(.W(SUM_W), .CNT_W(LZC_W)) u_lzc (
    .vec   (sum_q),
    .count (lzc)
  );

  // Without carry-out the hidden bit belongs one below the MSB, so the
  // normalising left shift is one less than the leading-zero count.
  always_comb begin : norm_path
    lshift   = lzc - 1'b1;
    norm_shl = sum_q[EXT_W-1:0] << lshift;
  end

  // ---------------------------------------------------------------- ROUND
  logic [MANT_W-1:0] rnd_mant;
  logic              rnd_up;
  logic [MANT_W:0]   rnd_sum;
  logic [EXPI_W-1:0] rnd_exp;
  logic [FRAC_W-1:0] rnd_frac;
  logic [WORD_W-1:0] result;

  always_comb begin : round_path
    rnd_mant = norm_q[EXT_W-1:3];
    // Round to nearest, ties to even.
    rnd_up   = norm_q[2] & (norm_q[1] | norm_q[0] | rnd_mant[0]);
    rnd_sum  = {1'b0, rnd_mant} + {{MANT_W{1'b0}}, rnd_up};
    if (rnd_sum[MANT_W]) begin
      rnd_exp  = exp_q + 1'b1;
      rnd_frac = rnd_sum[FRAC_W:1];
    end else begin
      rnd_exp  = exp_q;
      rnd_frac = rnd_sum[FRAC_W-1:0];
    end

    unique case (sp_q)
      SP_NAN:  result = QNAN;
      SP_INF:  result = sp_sign_q ? NEG_INF : POS_INF;
      SP_ZERO: result = {sp_sign_q, {(WORD_W-1){1'b0}}};
      default: begin
        if (norm_q == '0) begin
          result = '0;                                  // exact cancellation
        end else if (!rnd_exp[EXPI_W-1] && rnd_exp >= EXPI_W'(EXP_INF)) begin
          result = sign_q ? NEG_INF : POS_INF;
        end else if (rnd_exp[EXPI_W-1] || rnd_exp == '0) begin
          result = {sign_q, {(WORD_W-1){1'b0}}};        // underflow flush
        end else begin
          result = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
        end
      end
    endcase
  end

  // ------------------------------------------------------------ FSM + regs
  always_comb begin : next_state
    // NOTE: every *_d gets its hold value first so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    in_word_d  = in_word_q;
    last_d     = last_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    sp_d       = sp_q;
    sp_sign_d  = sp_sign_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    exp_d      = exp_q;
    a_ext_d    = a_ext_q;
    b_ext_d    = b_ext_q;
    sum_d      = sum_q;
    norm_d     = norm_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_word_d = in_data;
          last_d    = in_last;
          state_d   = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        sp_d      = al_sp;
        sp_sign_d = al_sp_sign;
        sign_d    = big_sign;
        sub_d     = op_acc.sign ^ op_in.sign;
        exp_d     = {{(EXPI_W-EXP_W){1'b0}}, big_exp};
        a_ext_d   = {big_mant, 3'b000};
        b_ext_d   = small_al;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        // A holds the larger magnitude, so the difference never goes negative.
        sum_d   = sub_q ? ({1'b0, a_ext_q} - {1'b0, b_ext_q})
                        : ({1'b0, a_ext_q} + {1'b0, b_ext_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        if (sum_q[SUM_W-1]) begin
          norm_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + 1'b1;
        end else begin
          norm_d = norm_shl;
          exp_d  = exp_q - {{(EXPI_W-LZC_W){1'b0}}, lshift};
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        acc_d = result;
        if (last_q) begin
          out_data_d = result;
          state_d    = ST_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      in_word_q  <= '0;
      last_q     <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
      sp_q       <= SP_NONE;
      sp_sign_q  <= 1'b0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      exp_q      <= '0;
      a_ext_q    <= '0;
      b_ext_q    <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_word_q  <= in_word_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      sp_q       <= sp_d;
      sp_sign_q  <= sp_sign_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      exp_q      <= exp_d;
      a_ext_q    <= a_ext_d;
      b_ext_q    <= b_ext_d;
      sum_q      <= sum_d;
      norm_q     <= norm_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp32_acc.sv
// Self-checking bench for fp32_acc: directed cases for the documented
// corner behaviour followed by randomized dot-product streams compared
// against a real-arithmetic reference model.
module tb_fp32_acc;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  fp32_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] acc_model;
  logic [31:0] seq [8];
  int          seq_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [31:0] w);
    real v;
    v = (1.0 + $itor(w[22:0]) / pow2(23)) * pow2(int'(w[30:23]) - 127);
    return w[31] ? -v : v;
  endfunction

  // Nonzero real -> FP32, round-nearest-even, overflow to INF, flush below.
  function automatic logic [31:0] from_real(input real v);
    logic s;
    real  m, scaled, fr;
    int   e, mi, be;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    scaled = m * pow2(23);
    mi     = $rtoi(scaled);
    fr     = scaled - $itor(mi);
    if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
    if (mi == (1 << 24)) begin mi = 1 << 23; e++; end
    be = e + 127;
    if (be >= 255) return s ? 32'hFF80_0000 : 32'h7F80_0000;
    if (be <= 0)   return {s, 31'b0};
    return {s, be[7:0], mi[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    real  s;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan)   return QNAN;
    if (a_inf && b_inf)   return (a[31] != b[31]) ? QNAN : a;
    if (a_inf)            return a;
    if (b_inf)            return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'b0};
    if (a_zero)           return b;
    if (b_zero)           return a;
    s = to_real(a) + to_real(b);
    if (s == 0.0) return 32'h0;
    return from_real(s);
  endfunction

  function automatic logic [31:0] rand_fp();
    int          r;
    logic        s;
    logic [22:0] f;
    r = int'($urandom_range(0, 99));
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    if (r < 2)  return {s, 8'hFF, f | 23'd1};
    if (r < 5)  return {s, 8'hFF, 23'd0};
    if (r < 9)  return {s, 8'h00, f};
    if (r < 13) return {s, 8'($urandom_range(250, 254)), f};
    if (r < 17) return {s, 8'($urandom_range(1, 8)), f};
    return {s, 8'($urandom_range(118, 136)), f};
  endfunction

  // ------------------------------------------------------------- drivers
  // Offers one element, then counts the busy cycles until the block is
  // either ready again or presenting its sum.
  task automatic send(input logic [31:0] w, input logic last);
    int guard = 0;
    int busy  = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    acc_model = ref_add(acc_model, w);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
    while (!in_ready && !out_valid && busy < 50) begin busy++; @(negedge clk); end
    check("busy_cycles", busy, 32'd4);
    if (last) check("out_valid_lat5", {31'b0, out_valid}, 32'd1);
    else      check("in_ready_back", {31'b0, in_ready}, 32'd1);
  endtask

  // Checks the presented sum, stalls the consumer for `hold` cycles while
  // poking in_valid, then completes the handshake.
  task automatic finish_sum(input int hold, output logic [31:0] got);
    int          guard = 0;
    logic [31:0] exp_sum;
    exp_sum = acc_model;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    check("out_valid", {31'b0, out_valid}, 32'd1);
    got = out_data;
    check("sum", out_data, exp_sum);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_data", out_data, exp_sum);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", {31'b0, out_valid}, 32'd0);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    acc_model = '0;
  endtask

  task automatic run_sum(input int hold, output logic [31:0] got);
    for (int i = 0; i < seq_n; i++) send(seq[i], i == seq_n - 1);
    finish_sum(hold, got);
  endtask

  task automatic dir2(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input int n, input logic [31:0] expv);
    logic [31:0] got;
    seq[0] = a;
    seq[1] = b;
    seq_n  = n;
    run_sum(0, got);
    check(tag, got, expv);
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------ sequence
  initial begin
    logic [31:0] got;
    logic [31:0] w;
    int          n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    acc_model = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);

    // Basic three-element sum.
    seq[0] = 32'h4000_0000;
    seq[1] = 32'h4040_0000;
    seq[2] = 32'h410C_0000;
    seq_n  = 3;
    run_sum(0, got);
    check("dir_basic", got, 32'h415C_0000);

    // Cancellation and rounding.
    dir2("dir_cancel",  32'h3FC0_0000, 32'hBFC0_0000, 2, 32'h0000_0000);
    dir2("dir_rne_tie", 32'h3F80_0000, 32'h3380_0000, 2, 32'h3F80_0000);
    dir2("dir_rne_up",  32'h3F80_0001, 32'h3380_0000, 2, 32'h3F80_0002);

    // Specials.
    dir2("dir_inf_inf", 32'h7F80_0000, 32'hFF80_0000, 2, 32'h7FC0_0000);
    dir2("dir_nan",     32'hFF80_0001, 32'h4000_0000, 2, 32'h7FC0_0000);
    dir2("dir_inf_fin", 32'h7F80_0000, 32'h4000_0000, 2, 32'h7F80_0000);

    // Overflow / underflow.
    dir2("dir_ovf",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 2, 32'h7F80_0000);
    dir2("dir_subn",    32'h0040_0000, 32'h0,         1, 32'h0000_0000);

    // Backpressure, then confirm the next sum starts from +0.
    seq[0] = 32'h3F80_0000;
    seq[1] = 32'h4000_0000;
    seq_n  = 2;
    run_sum(10, got);
    check("dir_bp", got, 32'h4040_0000);
    dir2("dir_after_bp", 32'h40A0_0000, 32'h0, 1, 32'h40A0_0000);

    // Reset while a non-last element is in NORM.
    in_data  = 32'h4000_0000;
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);                 // accepted; now in ALIGN
    in_valid = 1'b0;
    @(negedge clk);                 // ADD
    @(negedge clk);                 // NORM
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_data", out_data, 32'h0);
    rst = 1'b0;
    acc_model = '0;
    dir2("dir_after_rst", 32'h4040_0000, 32'h0, 1, 32'h4040_0000);

    // Randomized streams.
    for (int t = 0; t < 150; t++) begin
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        w = rand_fp();
        if ($urandom_range(0, 9) == 0 && acc_model[30:23] != 8'h00 && acc_model[30:23] != 8'hFF)
          w = acc_model ^ 32'h8000_0000;
        send(w, i == n - 1);
      end
      finish_sum(int'($urandom_range(0, 3)), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
